// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - GPR file with r0 hardwired to zero, write-through read bypass, HI/LO pair and commit counter
module wb_regfile #(
  parameter int REG_NUM = 32,
  parameter int REG_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       wb_wd,
  input  logic             wb_wreg,
  input  logic [REG_W-1:0] wb_wdata,
  input  logic [REG_W-1:0] wb_hi,
  input  logic [REG_W-1:0] wb_lo,
  input  logic             wb_whilo,
  input  logic             re1,
  input  logic             re2,
  input  logic [4:0]       raddr1,
  input  logic [4:0]       raddr2,
  output logic [REG_W-1:0] rdata1,
  output logic [REG_W-1:0] rdata2,
  output logic [REG_W-1:0] hi_o,
  output logic [REG_W-1:0] lo_o,
  output logic [31:0]      wb_cnt
);

  logic [REG_W-1:0] r_regs [REG_NUM];
  logic [REG_W-1:0] r_hi;
  logic [REG_W-1:0] r_lo;
  logic [31:0]      r_wb_cnt;
  logic             w_wr_en;
  logic [REG_W-1:0] w_rdata1;
  logic [REG_W-1:0] w_rdata2;

  // A write to r0 is dropped entirely: no storage update and no count.
  assign w_wr_en = wb_wreg && (wb_wd != 5'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_NUM; i++) begin
        r_regs[i] <= '0;
      end
      r_wb_cnt <= '0;
    end else if (w_wr_en) begin
      r_regs[wb_wd] <= wb_wdata;
      r_wb_cnt      <= r_wb_cnt + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (wb_whilo) begin
      r_hi <= wb_hi;
      r_lo <= wb_lo;
    end
  end

  // Bypass lets decode see the value being committed this very cycle.
  always_comb begin
    w_rdata1 = '0;
    if (!rst && re1 && (raddr1 != 5'd0)) begin
      if (wb_wreg && (raddr1 == wb_wd)) begin
        w_rdata1 = wb_wdata;
      end else begin
        w_rdata1 = r_regs[raddr1];
      end
    end
  end

  always_comb begin
    w_rdata2 = '0;
    if (!rst && re2 && (raddr2 != 5'd0)) begin
      if (wb_wreg && (raddr2 == wb_wd)) begin
        w_rdata2 = wb_wdata;
      end else begin
        w_rdata2 = r_regs[raddr2];
      end
    end
  end

  assign rdata1 = w_rdata1;
  assign rdata2 = w_rdata2;
  assign hi_o   = r_hi;
  assign lo_o   = r_lo;
  assign wb_cnt = r_wb_cnt;

endmodule

// File: tb/tb_wb_regfile.sv
// tb/tb_wb_regfile.sv - directed self-checking bench for wb_regfile
module tb_wb_regfile;

  logic        clk;
  logic        rst;
  logic [4:0]  wb_wd;
  logic        wb_wreg;
  logic [31:0] wb_wdata;
  logic [31:0] wb_hi;
  logic [31:0] wb_lo;
  logic        wb_whilo;
  logic        re1;
  logic        re2;
  logic [4:0]  raddr1;
  logic [4:0]  raddr2;
  logic [31:0] rdata1;
  logic [31:0] rdata2;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic [31:0] wb_cnt;

  int n_cmp;
  int n_bad;

  wb_regfile #(.REG_NUM(32), .REG_W(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .wb_wd    (wb_wd),
    .wb_wreg  (wb_wreg),
    .wb_wdata (wb_wdata),
    .wb_hi    (wb_hi),
    .wb_lo    (wb_lo),
    .wb_whilo (wb_whilo),
    .re1      (re1),
    .re2      (re2),
    .raddr1   (raddr1),
    .raddr2   (raddr2),
    .rdata1   (rdata1),
    .rdata2   (rdata2),
    .hi_o     (hi_o),
    .lo_o     (lo_o),
    .wb_cnt   (wb_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance past one rising edge and settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_wb();
    wb_wreg  = 1'b0;
    wb_whilo = 1'b0;
    wb_wd    = 5'd0;
    wb_wdata = 32'd0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    idle_wb();
    wb_hi = 32'd0; wb_lo = 32'd0;
    re1 = 1'b1; re2 = 1'b1;
    raddr1 = 5'd1; raddr2 = 5'd2;

    #12;
    check_eq("rst_rdata1", rdata1, 32'd0);
    check_eq("rst_rdata2", rdata2, 32'd0);
    check_eq("rst_hi", hi_o, 32'd0);
    check_eq("rst_lo", lo_o, 32'd0);
    check_eq("rst_cnt", wb_cnt, 32'd0);
    rst = 1'b0;

    // Preload r5 and HI, then reset mid-cycle
    #1;
    wb_wreg = 1'b1; wb_wd = 5'd5; wb_wdata = 32'h1234;
    wb_whilo = 1'b1; wb_hi = 32'hA; wb_lo = 32'hB;
    step();
    idle_wb();
    raddr1 = 5'd5;
    #1;
    check_eq("pre_r5", rdata1, 32'h1234);
    check_eq("pre_hi", hi_o, 32'hA);
    check_eq("pre_lo", lo_o, 32'hB);
    check_eq("pre_cnt", wb_cnt, 32'd1);
    rst = 1'b1;
    #1;
    check_eq("async_rdata1", rdata1, 32'd0);
    check_eq("async_hi", hi_o, 32'd0);
    check_eq("async_cnt", wb_cnt, 32'd0);
    #1;
    rst = 1'b0;
    #1;
    check_eq("post_rst_r5", rdata1, 32'd0);

    // Write held across an edge while in reset is discarded
    rst = 1'b1;
    wb_wreg = 1'b1; wb_wd = 5'd4; wb_wdata = 32'h99;
    step();
    idle_wb();
    rst = 1'b0;
    raddr1 = 5'd4;
    #1;
    check_eq("rst_write_r4", rdata1, 32'd0);
    check_eq("rst_write_cnt", wb_cnt, 32'd0);

    // Same-cycle bypass on both ports, then stored value
    wb_wreg = 1'b1; wb_wd = 5'd7; wb_wdata = 32'hDEADBEEF;
    raddr1 = 5'd7; raddr2 = 5'd7;
    #1;
    check_eq("byp_rdata1", rdata1, 32'hDEADBEEF);
    check_eq("byp_rdata2", rdata2, 32'hDEADBEEF);
    step();
    idle_wb();
    #1;
    check_eq("stored_rdata1", rdata1, 32'hDEADBEEF);
    check_eq("stored_rdata2", rdata2, 32'hDEADBEEF);
    check_eq("cnt_after_r7", wb_cnt, 32'd1);

    // Bypass overrides stale stored value; disabled write is ignored
    wb_wreg = 1'b1; wb_wd = 5'd7; wb_wdata = 32'h0BADF00D;
    #1;
    check_eq("byp_over_old", rdata1, 32'h0BADF00D);
    wb_wreg = 1'b0;
    #1;
    check_eq("no_byp_wreg0", rdata1, 32'hDEADBEEF);
    step();
    check_eq("wreg0_hold_r7", rdata1, 32'hDEADBEEF);
    check_eq("wreg0_cnt", wb_cnt, 32'd1);
    idle_wb();

    // r0 protection
    wb_wreg = 1'b1; wb_wd = 5'd0; wb_wdata = 32'hFFFFFFFF;
    raddr1 = 5'd0;
    #1;
    check_eq("r0_same_cycle", rdata1, 32'd0);
    step();
    idle_wb();
    #1;
    check_eq("r0_after", rdata1, 32'd0);
    check_eq("r0_cnt", wb_cnt, 32'd1);

    // Read enable gating
    wb_wreg = 1'b1; wb_wd = 5'd3; wb_wdata = 32'h55;
    step();
    idle_wb();
    re1 = 1'b0; raddr1 = 5'd3;
    #1;
    check_eq("re1_off", rdata1, 32'd0);
    re1 = 1'b1;
    #1;
    check_eq("re1_on", rdata1, 32'h55);
    check_eq("cnt_after_r3", wb_cnt, 32'd2);

    // HI/LO and GPR write in the same cycle
    wb_whilo = 1'b1; wb_hi = 32'h1; wb_lo = 32'h2;
    wb_wreg = 1'b1; wb_wd = 5'd9; wb_wdata = 32'h900;
    raddr2 = 5'd9;
    #1;
    check_eq("hi_commit_cycle", hi_o, 32'd0);
    check_eq("lo_commit_cycle", lo_o, 32'd0);
    check_eq("r9_byp", rdata2, 32'h900);
    step();
    idle_wb();
    wb_hi = 32'h7; wb_lo = 32'h8;
    #1;
    check_eq("hi_after", hi_o, 32'h1);
    check_eq("lo_after", lo_o, 32'h2);
    check_eq("r9_after", rdata2, 32'h900);
    check_eq("cnt_after_r9", wb_cnt, 32'd3);
    step();
    check_eq("hi_hold", hi_o, 32'h1);
    check_eq("lo_hold", lo_o, 32'h2);

    // Counter wrap
    force dut.r_wb_cnt = 32'hFFFFFFFF;
    #1;
    release dut.r_wb_cnt;
    #1;
    check_eq("cnt_forced", wb_cnt, 32'hFFFFFFFF);
    wb_wreg = 1'b1; wb_wd = 5'd2; wb_wdata = 32'h22;
    step();
    idle_wb();
    raddr2 = 5'd2;
    #1;
    check_eq("cnt_wrap", wb_cnt, 32'd0);
    check_eq("r2_after_wrap", rdata2, 32'h22);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
